seq_multiplier: RTL and testbench

Sequential shift-add unsigned multiplier. It is the inverse arithmetic unit to the restoring divider and uses the same en/Select/Busy/Ready handshake, so the control FSM can drive either unit with identical sequencing. It produces a 2*WIDTH-bit product, one multiplier bit per cycle, plus an overflow flag for results that do not fit in WIDTH bits.

---
 rtl/seq_multiplier.sv | 152 +++++++++++++++
 tb/tb_seq_multiplier.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/seq_multiplier.sv
// Sequential shift-add unsigned multiplier.
// Produces a 2*WIDTH-bit product, one multiplier bit per cycle, using the same
// en/Select/Busy/Ready handshake as the restoring divider. Ovf flags a product
// that does not fit in WIDTH bits.
module seq_multiplier #(
  parameter int unsigned WIDTH = 12
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic                 Select,
  input  logic [WIDTH-1:0]     Multiplicand1,
  input  logic [WIDTH-1:0]     Multiplicand2,
  input  logic [WIDTH-1:0]     Multiplier1,
  input  logic [WIDTH-1:0]     Multiplier2,
  output logic [2*WIDTH-1:0]   Res,
  output logic                 Ovf,
  output logic                 Busy,
  output logic                 Ready
);

  localparam int unsigned CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LastCount = CW'(WIDTH - 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] DONE = 2'd2;
  localparam logic [1:0] WAIT = 2'd3;

  logic [1:0]         state_q, state_d;
  // Multiplicand kept pre-shifted so each step adds A << count directly.
  logic [2*WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [CW-1:0]      count_q, count_d;
  logic [2*WIDTH-1:0] res_q, res_d;
  logic               ovf_q, ovf_d;
  logic               busy_q, busy_d;
  logic               ready_q, ready_d;

  logic [WIDTH-1:0]   sel_a;
  logic [WIDTH-1:0]   sel_b;

  // Operand pair chosen by Select; only consulted on the capture edge.
  always_comb begin
    sel_a = Select ? Multiplicand1 : Multiplicand2;
    sel_b = Select ? Multiplier1   : Multiplier2;
  end

  // Next-state and datapath for the IDLE/CALC/DONE/WAIT sequence.
  always_comb begin
    state_d  = state_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    count_d  = count_q;
    res_d    = res_q;
    ovf_d    = ovf_q;
    busy_d   = busy_q;
    ready_d  = ready_q;

    case (state_q)
      IDLE: begin
        if (en) begin
          mcand_d  = {{WIDTH{1'b0}}, sel_a};
          mplier_d = sel_b;
          acc_d    = '0;
          count_d  = '0;
          busy_d   = 1'b1;
          ready_d  = 1'b0;
          // A zero operand needs no iterations; acc is already the answer.
          state_d  = ((sel_a == '0) || (sel_b == '0)) ? DONE : CALC;
        end
      end

      CALC: begin
        if (!en) begin
          // Abort: drop back to idle, last published result is kept.
          busy_d  = 1'b0;
          ready_d = 1'b0;
          state_d = IDLE;
        end else begin
          if (mplier_q[0]) begin
            acc_d = acc_q + mcand_q;
          end
          mcand_d  = mcand_q << 1;
          mplier_d = mplier_q >> 1;
          count_d  = count_q + 1'b1;
          if (count_q == LastCount) begin
            state_d = DONE;
          end
        end
      end

      DONE: begin
        res_d   = acc_q;
        ovf_d   = |acc_q[2*WIDTH-1:WIDTH];
        busy_d  = 1'b0;
        ready_d = 1'b1;
        state_d = WAIT;
      end

      WAIT: begin
        // Requester must drop en for an edge before a new operation starts.
        if (!en) begin
          ready_d = 1'b0;
          state_d = IDLE;
        end
      end

      default: begin
        busy_d  = 1'b0;
        ready_d = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  // State registers with synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      count_q  <= '0;
      res_q    <= '0;
      ovf_q    <= 1'b0;
      busy_q   <= 1'b0;
      ready_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      count_q  <= count_d;
      res_q    <= res_d;
      ovf_q    <= ovf_d;
      busy_q   <= busy_d;
      ready_q  <= ready_d;
    end
  end

  // Outputs come straight from registers.
  always_comb begin
    Res   = res_q;
    Ovf   = ovf_q;
    Busy  = busy_q;
    Ready = ready_q;
  end

endmodule

// File: tb/tb_seq_multiplier.sv
// Self-checking bench for seq_multiplier: vector table, hand-written
// abort/reset/wait sequences and random operations against an arithmetic model.
module tb_seq_multiplier;

  localparam int unsigned W = 12;

  logic            clk = 1'b0;
  logic            rst;
  logic            en;
  logic            Select;
  logic [W-1:0]    Multiplicand1, Multiplicand2, Multiplier1, Multiplier2;
  logic [2*W-1:0]  Res;
  logic            Ovf, Busy, Ready;

  int total = 0;
  int bad   = 0;
  logic [2*W-1:0] last_res;
  logic           last_ovf;

  seq_multiplier #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .en(en), .Select(Select),
    .Multiplicand1(Multiplicand1), .Multiplicand2(Multiplicand2),
    .Multiplier1(Multiplier1), .Multiplier2(Multiplier2),
    .Res(Res), .Ovf(Ovf), .Busy(Busy), .Ready(Ready)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  typedef struct {
    logic          sel;
    logic [W-1:0]  a1, b1, a2, b2;
    logic [2*W-1:0] res;
    logic          ovf;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d (0x%0h) want %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  // Reference: plain integer product; overflow when it does not fit in W bits.
  task automatic model(input logic [W-1:0] a, input logic [W-1:0] b,
                       output logic [2*W-1:0] res, output logic ovf);
    longint unsigned p;
    p   = longint'(a) * longint'(b);
    res = p[2*W-1:0];
    ovf = (p >= (64'd1 << W));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Full operation from IDLE: capture, wait for Ready, hold, release en.
  task automatic run_op(input string tag, input logic sel,
                        input logic [W-1:0] a1, input logic [W-1:0] b1,
                        input logic [W-1:0] a2, input logic [W-1:0] b2,
                        input logic [2*W-1:0] exp_res, input logic exp_ovf,
                        input int hold);
    logic [W-1:0] a, b;
    int n, exp_lat, overlap, gap;
    logic got, stable;
    a = sel ? a1 : a2;
    b = sel ? b1 : b2;
    exp_lat = ((a == 0) || (b == 0)) ? 1 : W + 1;
    Select = sel;
    Multiplicand1 = a1; Multiplier1 = b1;
    Multiplicand2 = a2; Multiplier2 = b2;
    en = 1'b1;
    tick();
    check({tag, " busy_e0"}, 64'(Busy), 64'd1);
    check({tag, " ready_e0"}, 64'(Ready), 64'd0);
    // Operand/Select changes after capture must not matter.
    Select = ~sel;
    Multiplicand1 = W'($urandom); Multiplier1 = W'($urandom);
    Multiplicand2 = W'($urandom); Multiplier2 = W'($urandom);
    n = 0; got = 1'b0; overlap = 0; gap = 0;
    while (!got && n < 40) begin
      tick();
      n++;
      if (Busy && Ready) overlap++;
      if (!Busy && !Ready) gap++;
      if (Ready) got = 1'b1;
    end
    check({tag, " latency"}, 64'(n), 64'(exp_lat));
    check({tag, " res"}, 64'(Res), 64'(exp_res));
    check({tag, " ovf"}, 64'(Ovf), 64'(exp_ovf));
    check({tag, " busy_ready_excl"}, 64'(overlap + gap), 64'd0);
    stable = 1'b1;
    for (int i = 0; i < hold; i++) begin
      tick();
      if (!Ready || Busy || Res !== exp_res || Ovf !== exp_ovf) stable = 1'b0;
    end
    check({tag, " wait_hold"}, 64'(stable), 64'd1);
    en = 1'b0;
    tick();
    check({tag, " ready_fall"}, 64'(Ready), 64'd0);
    check({tag, " res_kept"}, 64'(Res), 64'(exp_res));
    last_res = exp_res;
    last_ovf = exp_ovf;
  endtask

  initial begin
    logic [W-1:0] ra, rb, rc, rd;
    logic rs;
    logic [2*W-1:0] er;
    logic eo;
    int n;
    logic got;

    vecs[0] = '{1'b1, 12'd25,   12'd13,   12'd0,    12'd0,    24'd325,      1'b0};
    vecs[1] = '{1'b0, 12'd2,    12'd3,    12'd4095, 12'd4095, 24'd16769025, 1'b1};
    vecs[2] = '{1'b1, 12'd0,    12'd77,   12'd9,    12'd9,    24'd0,        1'b0};
    vecs[3] = '{1'b1, 12'd64,   12'd64,   12'd0,    12'd0,    24'd4096,     1'b1};
    vecs[4] = '{1'b0, 12'd7,    12'd7,    12'd3,    12'd5,    24'd15,       1'b0};
    vecs[5] = '{1'b1, 12'd1,    12'd4095, 12'd0,    12'd0,    24'd4095,     1'b0};
    vecs[6] = '{1'b0, 12'd5,    12'd5,    12'd4095, 12'd0,    24'd0,        1'b0};
    vecs[7] = '{1'b1, 12'd63,   12'd65,   12'd0,    12'd0,    24'd4095,     1'b0};
    vecs[8] = '{1'b0, 12'd1,    12'd1,    12'd2,    12'd2048, 24'd4096,     1'b1};
    vecs[9] = '{1'b1, 12'd100,  12'd100,  12'd0,    12'd0,    24'd10000,    1'b1};

    rst = 1'b1; en = 1'b0; Select = 1'b0;
    Multiplicand1 = '0; Multiplicand2 = '0; Multiplier1 = '0; Multiplier2 = '0;
    last_res = '0; last_ovf = 1'b0;
    tick(); tick();
    check("reset res", 64'(Res), 64'd0);
    check("reset ovf", 64'(Ovf), 64'd0);
    check("reset busy", 64'(Busy), 64'd0);
    check("reset ready", 64'(Ready), 64'd0);
    rst = 1'b0;
    tick();
    check("idle busy", 64'(Busy), 64'd0);

    for (int i = 0; i < 10; i++) begin
      run_op($sformatf("vec%0d", i), vecs[i].sel, vecs[i].a1, vecs[i].b1,
             vecs[i].a2, vecs[i].b2, vecs[i].res, vecs[i].ovf, 2);
    end

    // Abort: en dropped at edge 5 of 100*100.
    Select = 1'b1; Multiplicand1 = 12'd100; Multiplier1 = 12'd100; en = 1'b1;
    tick();
    check("abort busy_e0", 64'(Busy), 64'd1);
    repeat (4) tick();
    en = 1'b0;
    tick();
    check("abort busy", 64'(Busy), 64'd0);
    check("abort ready", 64'(Ready), 64'd0);
    check("abort res_kept", 64'(Res), 64'(last_res));
    tick();
    check("abort idle_stays", 64'(Busy | Ready), 64'd0);
    run_op("after_abort", 1'b1, 12'd100, 12'd100, 12'd0, 12'd0, 24'd10000, 1'b1, 1);

    // Long WAIT hold: no restart while en stays high.
    run_op("hold20", 1'b1, 12'd25, 12'd13, 12'd0, 12'd0, 24'd325, 1'b0, 20);
    run_op("after_hold", 1'b1, 12'd64, 12'd64, 12'd0, 12'd0, 24'd4096, 1'b1, 1);

    // Reset mid-CALC.
    Select = 1'b1; Multiplicand1 = 12'd100; Multiplier1 = 12'd100; en = 1'b1;
    repeat (5) tick();
    rst = 1'b1;
    tick();
    check("rst_calc res", 64'(Res), 64'd0);
    check("rst_calc ovf", 64'(Ovf), 64'd0);
    check("rst_calc flags", 64'({Busy, Ready}), 64'd0);
    rst = 1'b0; en = 1'b0;
    tick();

    // Reset during WAIT.
    Select = 1'b0; Multiplicand2 = 12'd4095; Multiplier2 = 12'd4095; en = 1'b1;
    n = 0; got = 1'b0;
    while (!got && n < 40) begin
      tick();
      n++;
      if (Ready) got = 1'b1;
    end
    check("rst_wait reached", 64'(got), 64'd1);
    tick();
    rst = 1'b1;
    tick();
    check("rst_wait res", 64'(Res), 64'd0);
    check("rst_wait ovf", 64'(Ovf), 64'd0);
    check("rst_wait flags", 64'({Busy, Ready}), 64'd0);
    rst = 1'b0; en = 1'b0;
    tick();
    run_op("after_rst", 1'b1, 12'd3, 12'd5, 12'd0, 12'd0, 24'd15, 1'b0, 1);

    // Random operations against the arithmetic model.
    for (int i = 0; i < 40; i++) begin
      rs = 1'($urandom);
      ra = W'($urandom); rb = W'($urandom); rc = W'($urandom); rd = W'($urandom);
      if ($urandom_range(0, 7) == 0) begin
        if (rs) ra = '0; else rd = '0;
      end
      if ($urandom_range(0, 5) == 0) begin
        if (rs) begin ra = '1; rb = '1; end else begin rc = '1; rd = '1; end
      end
      if (rs) model(ra, rb, er, eo);
      else    model(rc, rd, er, eo);
      run_op($sformatf("rand%0d", i), rs, ra, rb, rc, rd, er, eo, $urandom_range(0, 3));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
